// File: rtl/alu_op_sequencer.sv
// Front-end for the registered 8-bit ALU: screens requests, drives the ALU, returns ordered responses.
// Defining ALU_SEQ_STATS_EN adds saturating stat_ops/stat_errs counters.
module alu_op_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STAT_W     = 16
) (
  input  logic        CLk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic [3:0]  req_op,
  input  logic        req_cin,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_cin,
  input  logic [15:0] alu_result,
  input  logic        alu_cout,
  input  logic        alu_zflag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_cout,
  output logic        rsp_zflag,
  output logic        rsp_err
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_ops,
  output logic [STAT_W-1:0] stat_errs
`endif
);

  localparam logic [3:0]       OP_ADD   = 4'h0;
  localparam logic [3:0]       OP_DIV   = 4'h3;
  localparam logic [3:0]       OP_LAST  = 4'h5;
  localparam logic [3:0]       OP_IDLE  = 4'hF;
  localparam int unsigned      PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned      USE_W    = CNT_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [USE_W-1:0] CREDITS  = USE_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [15:0] result;
    logic        cout;
    logic        zflag;
    logic        err;
  } rsp_t;

  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             alu_cin_q, alu_cin_d;
  logic             s1_v_q, s1_v_d, s1_err_q, s1_err_d, s1_add_q, s1_add_d;
  logic             s2_v_q, s2_v_d, s2_err_q, s2_err_d, s2_add_q, s2_add_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  rsp_t             fifo_mem_q [FIFO_DEPTH];

  logic             accept, req_err, push, pop;
  logic [USE_W-1:0] in_use;
  rsp_t             push_entry, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Every accepted-but-unpopped request holds a credit, so the FIFO can never overflow.
  assign in_use    = USE_W'(count_q) + USE_W'(s1_v_q) + USE_W'(s2_v_q);
  assign req_ready = !Reset && (in_use < CREDITS);
  assign accept    = req_valid && req_ready;
  assign req_err   = (req_op > OP_LAST) || ((req_op == OP_DIV) && (req_b == 8'h00));
  assign push      = s2_v_q;
  assign pop       = rsp_valid && rsp_ready;

  // Stage S1: rejected requests park the ALU on the idle opcode with zero operands.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    alu_cin_d = alu_cin_q;
    s1_v_d    = accept;
    s1_err_d  = s1_err_q;
    s1_add_d  = s1_add_q;
    if (accept) begin
      s1_err_d = req_err;
      s1_add_d = (req_op == OP_ADD);
      if (req_err) begin
        alu_a_d   = '0;
        alu_b_d   = '0;
        alu_op_d  = OP_IDLE;
        alu_cin_d = 1'b0;
      end else begin
        alu_a_d   = req_a;
        alu_b_d   = req_b;
        alu_op_d  = req_op;
        alu_cin_d = req_cin;
      end
    end
  end

  // Stage S2: the tag travels alongside the ALU's own result register.
  always_comb begin
    s2_v_d   = s1_v_q;
    s2_err_d = s1_err_q;
    s2_add_d = s1_add_q;
  end

  always_comb begin
    push_entry.result = s2_err_q ? 16'h0000 : alu_result;
    push_entry.zflag  = s2_err_q ? 1'b1 : alu_zflag;
    push_entry.cout   = (!s2_err_q && s2_add_q) ? alu_cout : 1'b0;
    push_entry.err    = s2_err_q;
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (Reset) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= OP_IDLE;
      alu_cin_q <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_add_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_err_q  <= 1'b0;
      s2_add_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      alu_cin_q <= alu_cin_d;
      s1_v_q    <= s1_v_d;
      s1_err_q  <= s1_err_d;
      s1_add_q  <= s1_add_d;
      s2_v_q    <= s2_v_d;
      s2_err_q  <= s2_err_d;
      s2_add_q  <= s2_add_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are visible.
  always_ff @(posedge CLk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
  end

  assign head       = fifo_mem_q[rd_ptr_q];
  assign rsp_valid  = (count_q != '0);
  assign rsp_result = head.result;
  assign rsp_cout   = head.cout;
  assign rsp_zflag  = head.zflag;
  assign rsp_err    = head.err;

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;
  assign alu_cin = alu_cin_q;

`ifdef ALU_SEQ_STATS_EN
  logic [STAT_W-1:0] stat_ops_q, stat_ops_d, stat_errs_q, stat_errs_d;

  always_comb begin
    stat_ops_d  = stat_ops_q;
    stat_errs_d = stat_errs_q;
    if (accept && (stat_ops_q != '1)) stat_ops_d = stat_ops_q + STAT_W'(1);
    if (push && s2_err_q && (stat_errs_q != '1)) stat_errs_d = stat_errs_q + STAT_W'(1);
  end

  always_ff @(posedge CLk) begin
    if (Reset) begin
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_errs = stat_errs_q;
`endif

  p_no_overflow: assert property (@(posedge CLk) disable iff (Reset)
    !(push && !pop && (count_q == FULL_CNT)));
  p_params_sane: assert property (@(posedge CLk) (FIFO_DEPTH >= 2) && (STAT_W >= 1));

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: stand-in registered ALU, scoreboard, vector table, random traffic.
module tb_alu_op_sequencer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] result;
    logic        cout;
    logic        zflag;
    logic        err;
  } rsp_t;

  typedef struct {
    rsp_t rsp;
    int   acc_cycle;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       cin;
    rsp_t       exp;
  } vec_t;

  logic        CLk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_a = '0, req_b = '0;
  logic [3:0]  req_op = '0;
  logic        req_cin = 1'b0;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_cin;
  logic [15:0] alu_result = '0;
  logic        alu_cout = 1'b0, alu_zflag = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_cout, rsp_zflag, rsp_err;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_errs;
`endif

  exp_t exp_q[$];
  rsp_t pending_exp = '0;
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   sb_ops = 0;
  int   sb_errs = 0;
  bit   alu_div0_seen = 1'b0;

  always #5 CLk = ~CLk;

  alu_op_sequencer #(.FIFO_DEPTH(DEPTH), .STAT_W(16)) dut (
    .CLk(CLk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zflag(alu_zflag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_zflag(rsp_zflag), .rsp_err(rsp_err)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
  );

  // Stand-in registered ALU; C_out is deliberately junk for non-ADD ops and illegal ops
  // produce a junk result, so the sequencer's masking is observable.
  function automatic logic [17:0] alu_fn(input logic [7:0] a, b, input logic [3:0] op, input logic cin);
    logic [15:0] r;
    logic        c;
    c = 1'b1;
    case (op)
      4'h0: begin r = 16'(a) + 16'(b) + 16'(cin); c = r[8]; end
      4'h1: r = 16'(a) - 16'(b);
      4'h2: r = 16'(a) * 16'(b);
      4'h3: r = (b == 8'h00) ? 16'hFFFF : 16'(a / b);
      4'h4: r = 16'(a & b);
      4'h5: r = 16'(a ^ b);
      default: r = 16'hDEAD;
    endcase
    return {(r == 16'h0000), c, r};
  endfunction

  always @(posedge CLk) begin
    if (Reset) begin
      alu_result <= '0;
      alu_cout   <= 1'b0;
      alu_zflag  <= 1'b1;
    end else begin
      {alu_zflag, alu_cout, alu_result} <= alu_fn(alu_a, alu_b, alu_op, alu_cin);
      if (alu_op == 4'h3 && alu_b == 8'h00) alu_div0_seen <= 1'b1;
    end
  end

  // Reference response straight from the request, using integer arithmetic.
  function automatic rsp_t ref_rsp(input logic [7:0] a, b, input logic [3:0] op, input logic cin);
    rsp_t r;
    int   v;
    if (op > 4'd5 || (op == 4'd3 && b == 8'd0)) begin
      r.result = 16'h0000; r.cout = 1'b0; r.zflag = 1'b1; r.err = 1'b1;
      return r;
    end
    case (op)
      4'd0:    v = int'(a) + int'(b) + int'(cin);
      4'd1:    v = int'(a) - int'(b);
      4'd2:    v = int'(a) * int'(b);
      4'd3:    v = int'(a) / int'(b);
      4'd4:    v = int'(a & b);
      default: v = int'(a ^ b);
    endcase
    r.result = v[15:0];
    r.cout   = (op == 4'd0) && (v > 255);
    r.zflag  = (r.result == 16'h0000);
    r.err    = 1'b0;
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] a, b, input logic [3:0] op, input logic cin,
                              input logic [15:0] res, input logic c, z, e);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.cin = cin;
    v.exp.result = res; v.exp.cout = c; v.exp.zflag = z; v.exp.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock: handshakes judged on pre-edge values, scoreboard updated, outputs checked after the edge.
  task automatic tick(output bit accepted);
    bit   acc, pop;
    rsp_t seen;
    exp_t e;
    #1;
    acc  = req_valid && req_ready;
    pop  = rsp_valid && rsp_ready;
    seen = {rsp_result, rsp_cout, rsp_zflag, rsp_err};
    @(posedge CLk);
    cycle++;
    if (Reset) begin
      exp_q.delete();
      sb_ops  = 0;
      sb_errs = 0;
    end else begin
      if (pop) begin
        check("rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_data", seen, e.rsp);
        end
      end
      if (acc) begin
        e.rsp = pending_exp;
        e.acc_cycle = cycle;
        exp_q.push_back(e);
        sb_ops++;
        if (pending_exp.err) sb_errs++;
      end
    end
    #1;
    check("req_ready", req_ready, !Reset && (exp_q.size() < DEPTH));
    check("rsp_valid", rsp_valid, (exp_q.size() != 0) && (exp_q[0].acc_cycle + 2 <= cycle));
    accepted = acc;
  endtask

  task automatic send(input logic [7:0] a, b, input logic [3:0] op, input logic cin, input rsp_t exp);
    bit acc;
    int n;
    n = 0;
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_cin = cin;
    pending_exp = exp;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 64);
    check("send_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      tick(acc);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_stats();
`ifdef ALU_SEQ_STATS_EN
    check("stat_ops", stat_ops, sb_ops);
    check("stat_errs", stat_errs, sb_errs);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[16];
    bit   acc;
    int   n;

    vecs[0]  = mk(8'hFF, 8'h01, 4'h0, 1'b1, 16'h0101, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(8'h05, 8'h05, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    vecs[2]  = mk(8'hFF, 8'hFF, 4'h2, 1'b0, 16'hFE01, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(8'hF0, 8'h0F, 4'h4, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(8'h3C, 8'h3C, 4'h5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(8'h0A, 8'h00, 4'h3, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    vecs[6]  = mk(8'h0A, 8'h03, 4'h9, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    vecs[7]  = mk(8'h0A, 8'h03, 4'h3, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(8'h03, 8'h05, 4'h1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(8'h00, 8'h00, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(8'h80, 8'h80, 4'h0, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(8'h12, 8'h34, 4'hF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
    vecs[12] = mk(8'h01, 8'h02, 4'h0, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0);
    vecs[13] = mk(8'h10, 8'h10, 4'h2, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(8'h00, 8'h01, 4'h1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(8'hFF, 8'h01, 4'h3, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0);

    // Reset, then idle.
    Reset = 1'b1;
    repeat (3) tick(acc);
    Reset = 1'b0;
    tick(acc);
    check("idle_rsp_valid", rsp_valid, 1'b0);
    check("idle_req_ready", req_ready, 1'b1);
    check("idle_alu_op", alu_op, 4'hF);
    check("idle_alu_a", alu_a, 8'h00);
    check("idle_alu_b", alu_b, 8'h00);
    check_stats();

    // Single ADD: response appears exactly two edges after the accept.
    rsp_ready = 1'b1;
    send(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].cin, vecs[0].exp);
    req_valid = 1'b0;
    tick(acc);
    check("lat_edge1_rsp_valid", rsp_valid, 1'b0);
    tick(acc);
    check("lat_edge2_rsp_valid", rsp_valid, 1'b1);
    check("lat_rsp", {rsp_result, rsp_cout, rsp_zflag, rsp_err}, {16'h0101, 1'b1, 1'b0, 1'b0});
    drain();

    // Vector table, back-to-back with rsp_ready held high.
    for (int i = 0; i < 16; i++) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, vecs[i].exp);
    drain();
    check_stats();

    // Back-pressure: only DEPTH requests may be outstanding.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_cin   = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      req_a  = 8'(n * 37 + 1);
      req_b  = 8'(n + 2);
      req_op = 4'(n % 6);
      pending_exp = ref_rsp(req_a, req_b, req_op, req_cin);
      tick(acc);
      if (acc) n++;
    end
    check("bp_accepts", n, DEPTH);
    check("bp_ready_low", req_ready, 1'b0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick(acc);
    check("bp_ready_reassert", req_ready, 1'b1);
    drain();

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_a   = 8'($urandom);
      req_b   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      req_op  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      req_cin = 1'($urandom);
      pending_exp = ref_rsp(req_a, req_b, req_op, req_cin);
      tick(acc);
    end
    drain();
    check_stats();

    // Reset with two requests in flight and two queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(8'(i + 1), 8'h02, 4'h0, 1'b0, ref_rsp(8'(i + 1), 8'h02, 4'h0, 1'b0));
    req_valid = 1'b0;
    Reset = 1'b1;
    tick(acc);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_req_ready", req_ready, 1'b0);
    check_stats();
    Reset = 1'b0;
    tick(acc);
    check("rst_ready_after", req_ready, 1'b1);
    rsp_ready = 1'b1;
    repeat (6) tick(acc);
    check("rst_no_stale", rsp_valid, 1'b0);
    check_stats();

    check("alu_never_div0", alu_div0_seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
